// File: rtl/i_cache_pkg.sv
// Shared widths, constants and FSM encoding for the direct-mapped instruction cache.
package i_cache_pkg;

    localparam int ADDR_LEN   = 32;
    localparam int INST_LEN   = 32;
    localparam int IC_ENTRIES = 128;

    localparam logic [INST_LEN-1:0] ZERO_WORD = '0;

    typedef enum logic [1:0] {
        IC_IDLE = 2'd0,
        IC_REQ  = 2'd1,
        IC_WAIT = 2'd2
    } ic_state_e;

    function automatic logic [ADDR_LEN-1:0] word_align(input logic [ADDR_LEN-1:0] addr);
        return {addr[ADDR_LEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the instruction cache: one write port, one combinational
// read port with tag compare, and a clear-all that takes priority over a same-cycle write.
module icache_array
    import i_cache_pkg::*;
#(
    parameter int ENTRIES = IC_ENTRIES,
    parameter int INDEX_W = $clog2(ENTRIES),
    parameter int TAG_W   = ADDR_LEN - INDEX_W - 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                we,
    input  logic [INDEX_W-1:0]  widx,
    input  logic [TAG_W-1:0]    wtag,
    input  logic [INST_LEN-1:0] wdata,
    input  logic [INDEX_W-1:0]  ridx,
    input  logic [TAG_W-1:0]    rtag,
    output logic                hit,
    output logic [INST_LEN-1:0] rdata
);

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]    tag_arr  [ENTRIES];
    logic [INST_LEN-1:0] data_arr [ENTRIES];

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (we) begin
            valid_q[widx] <= 1'b1;
        end
    end

    // NOTE: tag/data arrays are deliberately not reset; valid_q alone gates their use.
    always_ff @(posedge clk) begin
        if (we && !flush) begin
            tag_arr[widx]  <= wtag;
            data_arr[widx] <= wdata;
        end
    end

    always_comb begin
        hit   = valid_q[ridx] && (tag_arr[ridx] == rtag) && !flush;
        rdata = hit ? data_arr[ridx] : ZERO_WORD;
    end

endmodule

// File: rtl/i_cache.sv
// Direct-mapped, one-word-per-line instruction cache: combinational hit path plus a
// single-outstanding fill FSM talking req/gnt/valid to the memory controller.
module i_cache
    import i_cache_pkg::*;
#(
    parameter int ENTRIES = IC_ENTRIES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_LEN-1:0] addr_i,
    output logic                inst_available_o,
    output logic [INST_LEN-1:0] inst_o,
    input  logic                flush_i,
    output logic                mem_req_o,
    output logic [ADDR_LEN-1:0] mem_addr_o,
    input  logic                mem_gnt_i,
    input  logic                mem_valid_i,
    input  logic [INST_LEN-1:0] mem_data_i
);

    localparam int INDEX_W = $clog2(ENTRIES);
    localparam int TAG_W   = ADDR_LEN - INDEX_W - 2;

    ic_state_e           state_q, state_n;
    logic                req_q, req_n;
    logic [ADDR_LEN-1:0] miss_addr_q, miss_addr_n;
    logic                kill_q, kill_n;
    logic                fill_we;
    logic                hit;

    // Byte offset within the word is irrelevant to a word-per-line cache.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr_i[1:0];

    icache_array #(
        .ENTRIES (ENTRIES),
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .flush (flush_i),
        .we    (fill_we),
        .widx  (miss_addr_q[INDEX_W+1:2]),
        .wtag  (miss_addr_q[ADDR_LEN-1:INDEX_W+2]),
        .wdata (mem_data_i),
        .ridx  (addr_i[INDEX_W+1:2]),
        .rtag  (addr_i[ADDR_LEN-1:INDEX_W+2]),
        .hit   (hit),
        .rdata (inst_o)
    );

    assign inst_available_o = hit;
    assign mem_req_o        = req_q;
    assign mem_addr_o       = miss_addr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IC_IDLE;
            req_q       <= 1'b0;
            miss_addr_q <= '0;
            kill_q      <= 1'b0;
        end else begin
            state_q     <= state_n;
            req_q       <= req_n;
            miss_addr_q <= miss_addr_n;
            kill_q      <= kill_n;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_n     = state_q;
        req_n       = req_q;
        miss_addr_n = miss_addr_q;
        kill_n      = kill_q;
        fill_we     = 1'b0;
        unique case (state_q)
            IC_IDLE: begin
                if (!hit && !flush_i) begin
                    miss_addr_n = word_align(addr_i);
                    req_n       = 1'b1;
                    state_n     = IC_REQ;
                end
            end
            IC_REQ: begin
                if (flush_i) kill_n = 1'b1;
                if (mem_gnt_i) begin
                    req_n   = 1'b0;
                    state_n = IC_WAIT;
                end
            end
            IC_WAIT: begin
                // A flush racing the install is resolved inside the array (clear wins).
                if (mem_valid_i) begin
                    fill_we = !kill_q;
                    kill_n  = 1'b0;
                    state_n = IC_IDLE;
                end else if (flush_i) begin
                    kill_n = 1'b1;
                end
            end
            default: begin
                state_n = IC_IDLE;
                req_n   = 1'b0;
                kill_n  = 1'b0;
            end
        endcase
    end

endmodule
